// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory requesters, the decode hazard query
// and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] chk_addr0;
  logic [AW-1:0] chk_addr1;
  logic          hazard0;
  logic          hazard1;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  issue_en, issue_addr, chk_addr0, chk_addr1,
    output hazard0, hazard1,
    output rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output issue_en, issue_addr, chk_addr0, chk_addr1,
    input  hazard0, hazard1,
    input  rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (0) and
// load/multi-cycle (1) writebacks, plus a pending-write scoreboard for RAW checks.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** AW;

  logic            last_grant;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            accept0;
  logic            accept1;
  logic            wen_nxt;
  logic [AW-1:0]   waddr_nxt;
  logic [DW-1:0]   wdata_nxt;

  // Under contention only the requester that did not win last time is ready.
  always_comb begin
    bus.req0_ready = !rst && (!bus.req1_valid || last_grant);
    bus.req1_ready = !rst && (!bus.req0_valid || !last_grant);
    accept0        = bus.req0_valid && bus.req0_ready;
    accept1        = bus.req1_valid && bus.req1_ready;
  end

  always_comb begin
    wen_nxt   = 1'b0;
    waddr_nxt = bus.rf_waddr;
    wdata_nxt = bus.rf_wdata;
    if (accept0) begin
      wen_nxt   = (bus.req0_addr != '0);
      waddr_nxt = bus.req0_addr;
      wdata_nxt = bus.req0_data;
    end else if (accept1) begin
      wen_nxt   = (bus.req1_addr != '0);
      waddr_nxt = bus.req1_addr;
      wdata_nxt = bus.req1_data;
    end
  end

  // Set is applied after clear so a newly issued producer survives a commit.
  always_comb begin
    pending_nxt = pending;
    if (bus.rf_wen) pending_nxt[bus.rf_waddr] = 1'b0;
    if (bus.issue_en && (bus.issue_addr != '0)) pending_nxt[bus.issue_addr] = 1'b1;
  end

  always_comb begin
    bus.hazard0 = !rst && pending[bus.chk_addr0] && (bus.chk_addr0 != '0);
    bus.hazard1 = !rst && pending[bus.chk_addr1] && (bus.chk_addr1 != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      pending      <= '0;
      last_grant   <= 1'b1;
    end else begin
      bus.rf_wen   <= wen_nxt;
      bus.rf_waddr <= waddr_nxt;
      bus.rf_wdata <= wdata_nxt;
      pending      <= pending_nxt;
      if (accept0)      last_grant <= 1'b0;
      else if (accept1) last_grant <= 1'b1;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
- Requester 0 is the ALU writeback. Requester 1 is the load/multi-cycle writeback.
- Each requester uses a valid/ready handshake; requesters are served round-robin.
- Keeps a 32-entry pending-write scoreboard that the decode stage queries for RAW hazards on both read addresses. Sits between the execute/memory stages and the register file.

Parameters:
- DW, 32, data width of the write data
- AW, 5, register address width (2**AW scoreboard entries)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  AW  requester 0 destination register
- req0_data  input  DW  requester 0 write data
- req0_ready  output  1  requester 0 accepted this cycle when valid
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  AW  requester 1 destination register
- req1_data  input  DW  requester 1 write data
- req1_ready  output  1  requester 1 accepted this cycle when valid
- issue_en  input  1  decode issued an instruction that will write issue_addr
- issue_addr  input  AW  destination register of the issued instruction
- chk_addr0  input  AW  decode read address 0
- chk_addr1  input  AW  decode read address 1
- hazard0  output  1  chk_addr0 has an uncommitted write
- hazard1  output  1  chk_addr1 has an uncommitted write
- rf_wen  output  1  register file write enable (registered)
- rf_waddr  output  AW  register file write address (registered)
- rf_wdata  output  DW  register file write data (registered)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it takes effect only on a rising edge of clk.
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0
  - pending[all]=0
  - last_grant=1, so requester 0 wins the first conflict
  - While rst=1, req0_ready=req1_ready=0 and hazard0/1=0.
- Arbitration is combinational:
  - req0_ready = !rst && (!req1_valid || last_grant==1)
  - req1_ready = !rst && (!req0_valid || last_grant==0)
  - Accept_i = req_i_valid && req_i_ready. At most one accept per cycle.
- last_grant updates to i on every accept_i and holds otherwise. Alternation under continuous contention is strict: 0,1,0,1...
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not buffer.
- Write latency is 1 cycle. On the edge after accept_i:
  - rf_wen = (addr_i != 0)
  - rf_waddr = addr_i
  - rf_wdata = data_i
- With no accept, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
- Writes to register 0 are accepted (ready handshake completes) but never drive rf_wen=1 and never touch the scoreboard.
- Scoreboard:
  - pending[a] sets on the edge where issue_en=1 and issue_addr=a, for a!=0.
  - pending[a] clears on the edge at the end of a cycle where rf_wen=1 and rf_waddr=a, i.e. when the register file actually captures the data.
  - A set and a clear on the same address in the same cycle: set wins, because a newer producer exists.
  - A set on an already-pending entry leaves it at 1. The scoreboard is a bit vector, not a counter; decode must not issue a second writer to a pending register.
- Hazard outputs are combinational:
  - hazard0 = pending[chk_addr0] && chk_addr0!=0; hazard1 likewise.
  - The hazard reflects the pre-edge pending value. During the commit cycle, hazard stays 1 because the register file write is not yet visible.
- Reset mid-operation: an in-flight registered write is dropped (rf_wen=0 next cycle), pending is cleared, and no accept is reported during the reset cycle.
- Writes and reads through the register file are not bypassed here; forwarding is outside this block.

Test Plan:
- Reset then idle: assert rst 2 cycles, release. Required: rf_wen=0, req0_ready=req1_ready=1 with no valids, and hazard0/1=0 for chk_addr0=5, chk_addr1=31.
- Single requester latency: req0_valid=1, addr=3, data=0xDEADBEEF for one cycle. Required: req0_ready=1 that cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF; the cycle after, rf_wen=0.
- Contention round-robin: both valid for 4 cycles with req0 addr=1 and req1 addr=2, each requester dropping valid one cycle after its own accept and re-raising it. Required: accept order 0,1,0,1 and rf_waddr sequence 1,2,1,2 one cycle behind.
- Scoreboard lifecycle: issue_en with issue_addr=7; chk_addr0=7 gives hazard0=1. Then req1 writes addr 7. Required: hazard0=1 through the accept and commit cycles, and 0 the cycle after commit.
- Set/clear collision: pending[9]=1; commit of reg 9 (rf_wen=1, rf_waddr=9) in the same cycle as issue_en with issue_addr=9. Required: pending[9] stays 1 and hazard on 9 persists.
- Register-zero and mid-op reset:
  - req0 with addr=0: accepted, rf_wen stays 0; issue_en with issue_addr=0 gives hazard0=0 for chk_addr0=0.
  - Assert rst in the cycle after an accept. Required: rf_wen=0 the next cycle and all pending cleared.
